// File: rtl/ct_f_spsram_8192x32_ctrl_pkg.sv
// Shared types, default sizes and helper functions for the 8192x32 SRAM controller.
package ct_f_spsram_8192x32_ctrl_pkg;

    // Controller state: clear sweep or normal shared access.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

    // Widest byte-enable vector the mask helper handles (512-bit words).
    localparam int MAX_BE_WIDTH   = 64;

    // Expand byte enables into an active-high per-bit mask; callers trim the
    // result to their own data width.
    function automatic logic [MAX_BE_WIDTH*8-1:0] be_to_bitmask(input logic [MAX_BE_WIDTH-1:0] be);
        logic [MAX_BE_WIDTH*8-1:0] mask;
        mask = '0;
        for (int k = 0; k < MAX_BE_WIDTH; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ct_f_spsram_8192x32_ctrl_if.sv
// Requester-side bus of the SRAM controller: two request ports and the read responses.
interface ct_f_spsram_8192x32_ctrl_if
    import ct_f_spsram_8192x32_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int BEW = DATA_WIDTH / 8;

    logic                  req0_vld;
    logic                  req0_rdy;
    logic                  req0_wr;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [BEW-1:0]        req0_be;

    logic                  req1_vld;
    logic                  req1_rdy;
    logic                  req1_wr;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [BEW-1:0]        req1_be;

    logic                  rsp0_vld;
    logic                  rsp1_vld;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Requesters drive requests and sink grants and responses.
    modport master (
        output req0_vld, req0_wr, req0_addr, req0_wdata, req0_be,
        output req1_vld, req1_wr, req1_addr, req1_wdata, req1_be,
        input  req0_rdy, req1_rdy,
        input  rsp0_vld, rsp1_vld, rsp_data
    );

    // The controller sees requests and drives grants and responses.
    modport slave (
        input  req0_vld, req0_wr, req0_addr, req0_wdata, req0_be,
        input  req1_vld, req1_wr, req1_addr, req1_wdata, req1_be,
        output req0_rdy, req1_rdy,
        output rsp0_vld, rsp1_vld, rsp_data
    );

endinterface

// File: rtl/ct_f_spsram_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module ct_f_spsram_rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] vld,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;  // 0: req0 wins a tie, 1: req1 wins a tie

    // Pick at most one requester; a lone requester always wins.
    always_comb begin
        // NOTE: gnt gets a default before the branches so no path leaves it unassigned and no latch appears.
        gnt = 2'b00;
        if (en) begin
            case (vld)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After each grant, hand the tie-break to the other requester.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/ct_f_spsram_8192x32_ctrl.sv
// Access controller for one single-port SRAM macro: clear sweep, two-way
// round-robin sharing, byte-strobe expansion and read-response routing.
module ct_f_spsram_8192x32_ctrl
    import ct_f_spsram_8192x32_ctrl_pkg::*;
#(
    parameter int                      ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                      DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                      INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0]   INIT_VAL   = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       init_req,
    output logic                       init_done,
    ct_f_spsram_8192x32_ctrl_if.slave  bus,
    output logic [ADDR_WIDTH-1:0]      sram_a,
    output logic                       sram_cen,
    output logic                       sram_gwen,
    output logic [DATA_WIDTH-1:0]      sram_wen,
    output logic [DATA_WIDTH-1:0]      sram_d,
    input  logic [DATA_WIDTH-1:0]      sram_q
);

    localparam int                    BEW       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = {ADDR_WIDTH{1'b1}};
    localparam state_t                RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  rd_vld_q;
    logic                  rd_id_q;

    logic [1:0]            vld;
    logic [1:0]            gnt;
    logic                  arb_en;
    logic                  granted;
    logic                  sel;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BEW-1:0]        sel_be;

    // A pending clear request blocks arbitration for its cycle.
    assign vld     = {bus.req1_vld, bus.req0_vld};
    assign arb_en  = (state == ST_RUN) && !init_req;
    assign granted = |gnt;
    assign sel     = gnt[1];

    ct_f_spsram_rr_arb2 u_arb (
        .CLK (CLK),
        .RST (RST),
        .vld (vld),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign bus.req0_rdy = gnt[0];
    assign bus.req1_rdy = gnt[1];

    assign sel_wr    = sel ? bus.req1_wr    : bus.req0_wr;
    assign sel_addr  = sel ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = sel ? bus.req1_wdata : bus.req0_wdata;
    assign sel_be    = sel ? bus.req1_be    : bus.req0_be;

    assign init_done = (state == ST_RUN);

    // Drive the macro: sweep pattern in INIT, granted access or idle in RUN.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (state == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt;
            sram_d    = INIT_VAL;
        end else if (granted) begin
            sram_cen = 1'b0;
            sram_a   = sel_addr;
            if (sel_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~(DATA_WIDTH'(be_to_bitmask(MAX_BE_WIDTH'(sel_be))));
                sram_d    = sel_wdata;
            end
        end
    end

    // Controller state machine and clear-sweep address counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= RST_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Remember which requester issued the read so its data returns to it next cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld_q <= 1'b0;
            rd_id_q  <= 1'b0;
        end else begin
            rd_vld_q <= granted && !sel_wr;
            rd_id_q  <= sel;
        end
    end

    assign bus.rsp0_vld = rd_vld_q && !rd_id_q;
    assign bus.rsp1_vld = rd_vld_q &&  rd_id_q;
    assign bus.rsp_data = sram_q;

endmodule

// File: tb/tb_ct_f_spsram_8192x32_ctrl.sv
// Randomised scoreboard bench for the SRAM controller with a behavioural macro model.
module tb_ct_f_spsram_8192x32_ctrl;

    localparam int              AW    = 13;
    localparam int              DW    = 32;
    localparam int              BW    = DW / 8;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   IV    = 32'hDEAD_BEEF;

    typedef struct packed {
        logic          vld;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int unsigned due;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          init_req = 1'b0;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int          last_gnt = 1;
    logic [DW-1:0] sram_mem [DEPTH];

    ct_f_spsram_8192x32_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_f_spsram_8192x32_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_EN    (1),
        .INIT_VAL   (IV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .init_req  (init_req),
        .init_done (init_done),
        .bus       (bus),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Macro model: bit-masked write, or Q one cycle after a read.
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic req_t rd(input logic [AW-1:0] a);
        req_t r = '0;
        r.vld = 1'b1; r.addr = a;
        return r;
    endfunction

    function automatic req_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_t r;
        r.vld = 1'b1; r.wr = 1'b1; r.addr = a; r.wdata = d; r.be = be;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.vld   = ($urandom_range(0, 3) != 0);
        r.wr    = $urandom_range(0, 1) == 1;
        r.addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        r.wdata = $urandom;
        r.be    = BW'($urandom_range(0, 15));
        return r;
    endfunction

    // Active-low write mask the macro should see for a given byte-enable set.
    function automatic logic [DW-1:0] exp_wen(input logic [BW-1:0] be);
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = !be[i / 8];
        return w;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [BW-1:0] be);
        logic [DW-1:0] m = old;
        for (int k = 0; k < BW; k++) if (be[k]) m[8*k +: 8] = nw[8*k +: 8];
        return m;
    endfunction

    // One RUN-mode cycle: apply both requests, predict the grant and the macro pins.
    task automatic drive(input req_t r0, input req_t r1, input bit ireq);
        int   g;
        req_t r;
        @(negedge CLK);
        bus.req0_vld = r0.vld; bus.req0_wr = r0.wr; bus.req0_addr = r0.addr;
        bus.req0_wdata = r0.wdata; bus.req0_be = r0.be;
        bus.req1_vld = r1.vld; bus.req1_wr = r1.wr; bus.req1_addr = r1.addr;
        bus.req1_wdata = r1.wdata; bus.req1_be = r1.be;
        init_req = ireq;
        #1;
        g = -1;
        if (!ireq) begin
            if (r0.vld && r1.vld) g = (last_gnt == 0) ? 1 : 0;
            else if (r0.vld)      g = 0;
            else if (r1.vld)      g = 1;
        end
        check("rdy0", bus.req0_rdy, g == 0);
        check("rdy1", bus.req1_rdy, g == 1);
        check("init_done_run", init_done, 1);
        if (g >= 0) begin
            r = (g == 1) ? r1 : r0;
            last_gnt = g;
            check("acc_cen", sram_cen, 0);
            check("acc_a", sram_a, r.addr);
            if (r.wr) begin
                check("wr_gwen", sram_gwen, 0);
                check("wr_wen", sram_wen, exp_wen(r.be));
                check("wr_d", sram_d, r.wdata);
                ref_mem[r.addr] = merge(ref_mem[r.addr], r.wdata, r.be);
            end else begin
                check("rd_gwen", sram_gwen, 1);
                check("rd_wen", sram_wen, {DW{1'b1}});
                exp_q.push_back('{id: g, data: ref_mem[r.addr], due: cyc + 1});
            end
        end else begin
            check("idle_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {2'b11, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}});
        end
    endtask

    // Follow a clear sweep from cnt=0 while both requesters ask to read; expect a full-depth sweep.
    task automatic wait_sweep(input string tag);
        int n = 0;
        bit done = 0;
        @(negedge CLK);
        init_req = 1'b0;
        bus.req0_vld = 1'b1; bus.req0_wr = 1'b0;
        bus.req1_vld = 1'b1; bus.req1_wr = 1'b0;
        #1;
        while (!done) begin
            if (init_done) begin
                done = 1;
            end else if (n > DEPTH + 16) begin
                check({tag, "_timeout"}, 1, 0);
                done = 1;
            end else begin
                check("sweep_a", sram_a, n[AW-1:0]);
                check("sweep_ctl", {sram_cen, sram_gwen, bus.req0_rdy, bus.req1_rdy, init_done}, 0);
                check("sweep_wen_d", {sram_wen, sram_d}, {{DW{1'b0}}, IV});
                n++;
                @(negedge CLK);
                #1;
            end
        end
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        check(tag, n, DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
    endtask

    // Response monitor: pops the scoreboard whenever a response pulse is visible.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST) begin
            check("rsp_onehot", bus.rsp0_vld && bus.rsp1_vld, 0);
            if (bus.rsp0_vld || bus.rsp1_vld) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", bus.rsp1_vld ? 1 : 0, e.id);
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_latency", cyc, e.due);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                check("rsp_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        req_t idle = '0;
        bus.req0_vld = 0; bus.req0_wr = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_be = '0;
        bus.req1_vld = 0; bus.req1_wr = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_be = '0;

        // Reset values: sweep pattern at address 0, no grants, no responses.
        #1;
        check("rst_outputs", {init_done, bus.rsp0_vld, bus.rsp1_vld, bus.req0_rdy, bus.req1_rdy}, 0);
        check("rst_sweep_pins", {sram_cen, sram_gwen, sram_a, sram_d}, {2'b00, {AW{1'b0}}, IV});
        repeat (3) @(posedge CLK);
        #1;
        check("rst_hold_a", sram_a, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_sweep("sweep_len_after_rst");

        // Reads of the first, middle and last words return the clear value.
        drive(rd(13'd0), idle, 0);
        drive(idle, idle, 0);
        drive(rd(13'd4095), idle, 0);
        drive(rd(13'd8191), idle, 0);
        drive(idle, idle, 0);

        // Partial write over a zeroed word.
        drive(wr(13'h0123, 32'h0, 4'hF), idle, 0);
        drive(wr(13'h0123, 32'h1122_3344, 4'b0101), idle, 0);
        check("wen_be0101", sram_wen, 32'hFF00_FF00);
        drive(rd(13'h0123), idle, 0);
        drive(idle, idle, 0);

        // Write with no byte enables leaves the word unchanged.
        drive(wr(13'h0123, 32'hFFFF_FFFF, 4'b0000), idle, 0);
        drive(idle, rd(13'h0123), 0);

        // Both requesters reading for six cycles: grants alternate.
        for (int i = 0; i < 6; i++) drive(rd(AW'(i)), rd(AW'(100 + i)), 0);

        // Lone requester 1 is granted every cycle.
        for (int i = 0; i < 3; i++) drive(idle, rd(AW'(200 + i)), 0);

        // Write then read of the same address across requesters.
        drive(wr(13'h0042, 32'hCAFE_F00D, 4'hF), rd(13'h0042), 0);
        drive(idle, rd(13'h0042), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) drive(rnd_req(), rnd_req(), 0);
        drive(idle, idle, 0);

        // Clear request right after a read: response still arrives, then a full sweep.
        drive(rd(13'd5), idle, 0);
        drive(rd(13'd6), rd(13'd7), 1);
        wait_sweep("sweep_len_init_req");
        drive(rd(13'd5), idle, 0);
        drive(idle, rd(13'h0123), 0);
        drive(idle, idle, 0);

        // Reset in the middle of a sweep restarts it from address 0.
        drive(idle, idle, 1);
        repeat (101) @(negedge CLK);
        #1;
        check("mid_sweep_a", sram_a, 100);
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_outputs", {init_done, bus.rsp0_vld, bus.rsp1_vld}, 0);
        check("async_rst_a", sram_a, 0);
        check("rst_flush", exp_q.size(), 0);
        exp_q.delete();
        last_gnt = 1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_sweep("sweep_len_mid_rst");
        drive(rd(13'd100), rd(13'd0), 0);
        drive(idle, idle, 0);
        drive(idle, idle, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
